// File: rtl/modmul_dmr.sv
// Dual-modular-redundant modular multiplier for NTT butterflies.
// Each lane computes (in_b * twiddle) mod MODULUS on two independent
// paths (main, shadow). The results travel down a LATENCY-deep pipeline
// together with in_a and are compared at the output. Disagreement raises
// a per-lane mismatch flag, a sticky alarm and a saturating error count.
module modmul_dmr #(
  parameter int WIDTH   = 14,
  parameter int MODULUS = 12289,
  parameter int LANES   = 2,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] twiddle,
  input  logic [LANES-1:0]       fault_inj,
  input  logic                   clr_alarm,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_e,
  output logic [LANES*WIDTH-1:0] out_o,
  output logic [LANES-1:0]       mismatch,
  output logic                   alarm,
  output logic [CNT_W-1:0]       err_count
);

  localparam int                 LW      = LANES * WIDTH;
  localparam logic [2*WIDTH-1:0] Q       = (2*WIDTH)'(MODULUS);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // Full-width products, kept separate per path.
  logic [2*WIDTH-1:0] main_prod   [LANES];
  logic [2*WIDTH-1:0] shadow_prod [LANES];
  logic [LW-1:0]      main_red;
  logic [LW-1:0]      shadow_red;

  // Pipeline state, stage LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] valid_q,  valid_d;
  logic [LW-1:0]      a_q      [LATENCY];
  logic [LW-1:0]      a_d      [LATENCY];
  logic [LW-1:0]      main_q   [LATENCY];
  logic [LW-1:0]      main_d   [LATENCY];
  logic [LW-1:0]      shadow_q [LATENCY];
  logic [LW-1:0]      shadow_d [LATENCY];

  logic               alarm_q, alarm_d;
  logic [CNT_W-1:0]   err_q,   err_d;
  logic               any_mm;

  // Main path: full product then reduction mod MODULUS.
  always_comb begin
    main_red = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      main_prod[i] = {{WIDTH{1'b0}}, in_b[i*WIDTH +: WIDTH]} *
                     {{WIDTH{1'b0}}, twiddle[i*WIDTH +: WIDTH]};
      main_red[i*WIDTH +: WIDTH] = WIDTH'(main_prod[i] % Q);
    end
  end

  // Shadow path: independent copy, with optional bit-0 corruption for test.
  always_comb begin
    shadow_red = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      shadow_prod[i] = {{WIDTH{1'b0}}, twiddle[i*WIDTH +: WIDTH]} *
                       {{WIDTH{1'b0}}, in_b[i*WIDTH +: WIDTH]};
      shadow_red[i*WIDTH +: WIDTH] = WIDTH'(shadow_prod[i] % Q) ^
                                     WIDTH'(fault_inj[i] & in_valid);
    end
  end

  // Next-state of the shift pipeline; data is captured every cycle so
  // bubbles stay deterministic.
  always_comb begin
    valid_d[0]  = in_valid;
    a_d[0]      = in_a;
    main_d[0]   = main_red;
    shadow_d[0] = shadow_red;
    for (int unsigned s = 1; s < LATENCY; s++) begin
      valid_d[s]  = valid_q[s-1];
      a_d[s]      = a_q[s-1];
      main_d[s]   = main_q[s-1];
      shadow_d[s] = shadow_q[s-1];
    end
  end

  // Per-lane comparison at the output stage, qualified by out_valid.
  always_comb begin
    mismatch = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      mismatch[i] = valid_q[LATENCY-1] &&
                    (main_q[LATENCY-1][i*WIDTH +: WIDTH] !=
                     shadow_q[LATENCY-1][i*WIDTH +: WIDTH]);
    end
  end

  assign any_mm = |mismatch;

  // Sticky alarm and saturating error count; a mismatch beats a clear.
  always_comb begin
    alarm_d = alarm_q;
    err_d   = err_q;
    if (any_mm) begin
      alarm_d = 1'b1;
      if (clr_alarm)
        err_d = CNT_W'(1);
      else if (err_q != CNT_MAX)
        err_d = err_q + 1'b1;
    end else if (clr_alarm) begin
      alarm_d = 1'b0;
      err_d   = '0;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      alarm_q <= 1'b0;
      err_q   <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        a_q[s]      <= '0;
        main_q[s]   <= '0;
        shadow_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        a_q[s]      <= a_d[s];
        main_q[s]   <= main_d[s];
        shadow_q[s] <= shadow_d[s];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_e     = a_q[LATENCY-1];
  assign out_o     = main_q[LATENCY-1];
  assign alarm     = alarm_q;
  assign err_count = err_q;

endmodule
